radiant_trig_coinc: RTL

RADIANT_TRIG_COINC -- requirements
Module: radiant_trig_coinc

---
 rtl/radiant_trig_coinc.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/radiant_trig_coinc.sv
// Multi-channel trigger coincidence unit: synchronised edge detection, per-channel windows,
// majority vote, holdoff FSM and optional per-channel scalers (RADIANT_TRIG_COINC_SCALER_EN).
module radiant_trig_coinc #(
    parameter int               NCHAN         = 24,
    parameter int               WINDOW_BITS   = 8,
    parameter int               HOLDOFF_BITS  = 16,
    parameter int               SCALER_BITS   = 16,
    parameter logic [NCHAN-1:0] TRIG_POLARITY = {NCHAN{1'b0}}
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NCHAN-1:0]           trig_i,
    input  logic                       enable_i,
    input  logic [NCHAN-1:0]           mask_i,
    input  logic [$clog2(NCHAN+1)-1:0] majority_i,
    input  logic [WINDOW_BITS-1:0]     window_i,
    input  logic [HOLDOFF_BITS-1:0]    holdoff_i,
    input  logic                       pps_i,
    input  logic [4:0]                 scaler_sel_i,
    output logic                       trig_o,
    output logic [NCHAN-1:0]           trig_pattern_o,
    output logic [31:0]                trig_count_o,
    output logic                       busy_o,
    output logic [SCALER_BITS-1:0]     scaler_o
);
    // state    | meaning
    // DISABLED | coincidence logic idle, enable_i low
    // ARMED    | waiting for registered majority compare
    // HOLDOFF  | dead time after a trigger, busy_o high
    typedef enum logic [1:0] {DISABLED, ARMED, HOLDOFF} state_t;

    localparam int MAJ_W = $clog2(NCHAN+1);

    logic [NCHAN-1:0]       sync1, sync2, sync3;
    logic [NCHAN-1:0]       edge_det, active, act_q, pat_q;
    logic [WINDOW_BITS-1:0] win_cnt [NCHAN];
    logic [MAJ_W-1:0]       pop;
    logic                   maj_ok, cmp_q;
    state_t                 state, state_nxt;
    logic [HOLDOFF_BITS-1:0] hold_cnt, hold_nxt;
    logic                   trig_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= trig_i ^ TRIG_POLARITY;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_det = sync2 & ~sync3;

    // Window counters run regardless of FSM state; an edge always reloads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NCHAN; i++) win_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (edge_det[i])
                    win_cnt[i] <= window_i;
                else if (win_cnt[i] != '0)
                    win_cnt[i] <= win_cnt[i] - WINDOW_BITS'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCHAN; i++) active[i] = edge_det[i] | (win_cnt[i] != '0);
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NCHAN; i++) pop = pop + MAJ_W'(act_q[i]);
    end

    assign maj_ok = (majority_i != '0) && (int'(majority_i) <= NCHAN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            act_q <= '0;
            pat_q <= '0;
            cmp_q <= 1'b0;
        end else begin
            act_q <= active & ~mask_i;
            pat_q <= act_q;
            cmp_q <= maj_ok && (pop >= majority_i);
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        trig_nxt  = 1'b0;
        case (state)
            DISABLED: if (enable_i) state_nxt = ARMED;
            ARMED: begin
                if (cmp_q) begin
                    trig_nxt  = 1'b1;
                    state_nxt = HOLDOFF;
                    hold_nxt  = holdoff_i;
                end
            end
            HOLDOFF: begin
                if (hold_cnt <= HOLDOFF_BITS'(1))
                    state_nxt = ARMED;
                else
                    hold_nxt = hold_cnt - HOLDOFF_BITS'(1);
            end
            default: state_nxt = DISABLED;
        endcase
        if (!enable_i) begin
            state_nxt = DISABLED;
            trig_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= DISABLED;
            hold_cnt       <= '0;
            trig_o         <= 1'b0;
            trig_pattern_o <= '0;
            trig_count_o   <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            trig_o   <= trig_nxt;
            if (trig_nxt) begin
                trig_pattern_o <= pat_q;
                trig_count_o   <= trig_count_o + 32'd1;
            end
        end
    end

    assign busy_o = (state == HOLDOFF);

`ifdef RADIANT_TRIG_COINC_SCALER_EN
    logic [SCALER_BITS-1:0] scaler [NCHAN];
    logic [SCALER_BITS-1:0] bank   [NCHAN];

    // An edge coincident with pps starts the new period at 1.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NCHAN; i++) begin
                scaler[i] <= '0;
                bank[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (pps_i) begin
                    bank[i]   <= scaler[i];
                    scaler[i] <= SCALER_BITS'(edge_det[i]);
                end else if (edge_det[i] && (scaler[i] != '1)) begin
                    scaler[i] <= scaler[i] + SCALER_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            scaler_o <= '0;
        else if (int'(scaler_sel_i) < NCHAN)
            scaler_o <= bank[scaler_sel_i];
        else
            scaler_o <= '0;
    end
`else
    logic unused_scaler_inputs;
    assign unused_scaler_inputs = ^{pps_i, scaler_sel_i};
    assign scaler_o = '0;
`endif

endmodule
